// File: rtl/window_bram.sv
`default_nettype none
// ============================================================================
// Module   : window_bram
// Brief    : Circular sliding-window sample buffer with PORTS offset-addressed
//            read ports. Define WINDOW_BRAM_BYPASS_EN for same-cycle write forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module window_bram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 21,
  parameter int PORTS      = 3,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wr_valid,
  output logic                         o_wr_ready,
  input  logic [DATA_WIDTH-1:0]        i_wr_data,
  input  logic                         i_release,
  input  logic                         i_rd_en,
  input  logic [ADDR_WIDTH*PORTS-1:0]  i_rd_offs,
  output logic [DATA_WIDTH*PORTS-1:0]  o_rd_data,
  output logic                         o_rd_valid,
  output logic [PORTS-1:0]             o_rd_oob,
  output logic [ADDR_WIDTH:0]          o_fill,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int                  c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_FONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [c_IDX_W-1:0]  c_LAST   = c_IDX_W'(DEPTH-1);
  localparam logic [c_IDX_W-1:0]  c_PONE   = c_IDX_W'(1);

  logic [DATA_WIDTH-1:0]       r_mem [0:DEPTH-1];
  logic [c_IDX_W-1:0]          r_wp;
  logic [c_IDX_W-1:0]          r_tp;
  logic [ADDR_WIDTH:0]         r_fill;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_wr_fire;
  logic                        w_rel_fire;
  logic [DATA_WIDTH*PORTS-1:0] w_rd_data;
  logic [PORTS-1:0]            w_rd_oob;
  logic [DATA_WIDTH*PORTS-1:0] r_rd_data;
  logic [PORTS-1:0]            r_rd_oob;
  logic                        r_rd_valid;

  assign w_full     = (r_fill == c_DEPTH);
  assign w_empty    = (r_fill == '0);
  // Ready comes from registered fill only, so a same-cycle release never opens a full buffer.
  assign w_wr_fire  = i_wr_valid && !w_full;
  assign w_rel_fire = i_release && !w_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp   <= '0;
      r_tp   <= '0;
      r_fill <= '0;
    end else begin
      if (w_wr_fire) begin
        r_wp <= (r_wp == c_LAST) ? '0 : r_wp + c_PONE;
      end
      if (w_rel_fire) begin
        r_tp <= (r_tp == c_LAST) ? '0 : r_tp + c_PONE;
      end
      case ({w_wr_fire, w_rel_fire})
        2'b10:   r_fill <= r_fill + c_FONE;
        2'b01:   r_fill <= r_fill - c_FONE;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once fill is cleared.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire) begin
      r_mem[r_wp] <= i_wr_data;
    end
  end

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] w_offs;
    logic [ADDR_WIDTH:0]   w_sum;
    logic [ADDR_WIDTH:0]   w_red;
    logic [c_IDX_W-1:0]    w_addr;
    logic                  w_inr;

    assign w_offs = i_rd_offs[ADDR_WIDTH*p +: ADDR_WIDTH];
    assign w_sum  = (ADDR_WIDTH+1)'(r_tp) + {1'b0, w_offs};
    assign w_red  = (w_sum >= c_DEPTH) ? (w_sum - c_DEPTH) : w_sum;
    assign w_addr = c_IDX_W'(w_red);
    assign w_inr  = ({1'b0, w_offs} < r_fill);

`ifdef WINDOW_BRAM_BYPASS_EN
    logic w_fwd;
    // offs == fill addresses the slot being written this cycle, i.e. mem[wp].
    assign w_fwd = w_wr_fire && ({1'b0, w_offs} == r_fill);
    assign w_rd_data[DATA_WIDTH*p +: DATA_WIDTH] = w_fwd ? i_wr_data :
                                                   (w_inr ? r_mem[w_addr] : '0);
    assign w_rd_oob[p] = !(w_inr || w_fwd);
`else
    assign w_rd_data[DATA_WIDTH*p +: DATA_WIDTH] = w_inr ? r_mem[w_addr] : '0;
    assign w_rd_oob[p] = !w_inr;
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_oob   <= '0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        r_rd_data <= w_rd_data;
        r_rd_oob  <= w_rd_oob;
      end
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_oob   = r_rd_oob;
  assign o_fill     = r_fill;
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_wr_ready = !w_full;

endmodule
`default_nettype wire

// File: tb/tb_window_bram.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_bram
// Brief    : Scoreboard bench for window_bram (honours WINDOW_BRAM_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_bram;
  localparam int DW    = 8;
  localparam int DEPTH = 21;
  localparam int PORTS = 3;
  localparam int AW    = 6;
`ifdef WINDOW_BRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                wr_valid;
  logic                wr_ready;
  logic [DW-1:0]       wr_data;
  logic                rel;
  logic                rd_en;
  logic [AW*PORTS-1:0] rd_offs;
  logic [DW*PORTS-1:0] rd_data;
  logic                rd_valid;
  logic [PORTS-1:0]    rd_oob;
  logic [AW:0]         fill;
  logic                full;
  logic                empty;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  q_win[$];
  logic [26:0] exp_q[$];

  always #5 clk = ~clk;

  window_bram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PORTS(PORTS), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_data(wr_data), .i_release(rel), .i_rd_en(rd_en), .i_rd_offs(rd_offs),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_rd_oob(rd_oob),
    .o_fill(fill), .o_full(full), .o_empty(empty)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] offs3(input int a, input int b, input int c);
    return {6'(c), 6'(b), 6'(a)};
  endfunction

  // Drives one cycle; expectations come from the reference window queue.
  task automatic step(input logic wv, input logic [7:0] wd, input logic rl,
                      input logic rd, input logic [17:0] offs, output logic acc);
    logic [26:0] e;
    logic        rel_ok;
    int          sz;
    int          o;
    sz     = q_win.size();
    acc    = wv && (sz < DEPTH);
    rel_ok = rl && (sz > 0);
    wr_valid = wv; wr_data = wd; rel = rl; rd_en = rd; rd_offs = offs;
    if (rd) begin
      e = '0;
      for (int p = 0; p < PORTS; p++) begin
        o = int'(offs[AW*p +: AW]);
        if (o < sz)                       e[DW*p +: DW] = q_win[o];
        else if (BYP && acc && (o == sz)) e[DW*p +: DW] = wd;
        else                              e[24+p] = 1'b1;
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rel_ok) void'(q_win.pop_front());
    if (acc) q_win.push_back(wd);
    @(negedge clk);
    wr_valid = 1'b0; rel = 1'b0; rd_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rd_spurious", 32'(rd_valid), 32'd0);
      end else begin
        logic [26:0] e;
        e = exp_q.pop_front();
        check_eq("rd_data", 32'(rd_data), 32'(e[23:0]));
        check_eq("rd_oob", 32'(rd_oob), 32'(e[26:24]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   nxt;
    int   rels;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rel = 1'b0; rd_en = 1'b0; rd_offs = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_oob", 32'(rd_oob), 32'd0);
    check_eq("rst_fill", 32'(fill), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_ready", 32'(wr_ready), 32'd1);
    rst = 1'b0;

    for (int k = 1; k <= 21; k++) step(1'b1, 8'(k), 1'b0, 1'b0, '0, acc);
    check_eq("full_flag", 32'(full), 32'd1);
    check_eq("full_ready", 32'(wr_ready), 32'd0);
    check_eq("full_fill", 32'(fill), 32'd21);
    step(1'b1, 8'd99, 1'b0, 1'b0, '0, acc);
    check_eq("over_write_fill", 32'(fill), 32'd21);

    step(1'b0, '0, 1'b0, 1'b1, offs3(0, 10, 20), acc);
    check_eq("rd_valid_on", 32'(rd_valid), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, '0, acc);
    check_eq("rd_valid_pulse", 32'(rd_valid), 32'd0);

    // Producer holds each sample until accepted while 5 releases are issued.
    nxt = 22; rels = 0;
    while (nxt <= 26 || rels < 5) begin
      step(nxt <= 26, 8'(nxt), rels < 5, 1'b0, '0, acc);
      if (acc) nxt++;
      if (rels < 5) rels++;
    end
    check_eq("slide_fill", 32'(fill), 32'd21);
    step(1'b0, '0, 1'b0, 1'b1, offs3(0, 20, 19), acc);

    for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b1, 1'b0, '0, acc);
    check_eq("fill3", 32'(fill), 32'd3);
    step(1'b0, '0, 1'b0, 1'b1, offs3(0, 3, 7), acc);
    step(1'b0, '0, 1'b1, 1'b1, offs3(0, 1, 2), acc);

    repeat (3) step(1'b0, '0, 1'b1, 1'b0, '0, acc);
    check_eq("empty_flag", 32'(empty), 32'd1);
    step(1'b1, 8'hAB, 1'b0, 1'b1, offs3(0, 1, 2), acc);
    step(1'b0, '0, 1'b0, 1'b1, offs3(0, 0, 1), acc);

    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)),
           offs3($urandom_range(0, 23), $urandom_range(0, 23), $urandom_range(0, 23)), acc);
      check_eq("rand_fill", 32'(fill), 32'(q_win.size()));
    end

    while (q_win.size() < 12) step(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0, '0, acc);
    while (q_win.size() > 12) step(1'b0, '0, 1'b1, 1'b0, '0, acc);
    step(1'b0, '0, 1'b0, 1'b1, offs3(0, 5, 11), acc);
    check_eq("pre_rst_fill", 32'(fill), 32'd12);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_rd_data", 32'(rd_data), 32'd0);
    check_eq("arst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("arst_rd_oob", 32'(rd_oob), 32'd0);
    check_eq("arst_fill", 32'(fill), 32'd0);
    check_eq("arst_full", 32'(full), 32'd0);
    check_eq("arst_empty", 32'(empty), 32'd1);
    check_eq("arst_ready", 32'(wr_ready), 32'd1);
    q_win.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0, 1'b0, 1'b1, offs3(0, 0, 0), acc);
    step(1'b0, '0, 1'b0, 1'b0, '0, acc);
    check_eq("rd_pending", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/window_bram.md
# window_bram

- Parametrised circular window buffer for the convolution datapath; successor to the fixed three-port slide BRAM.
- Accepts a pixel stream through a valid/ready write port and retains up to DEPTH samples in arrival order.
- PORTS independent read ports address samples by offset from the oldest retained sample. A release strobe retires the oldest sample so the window slides without the producer tracking absolute addresses.
- Sits between the input pixel feeder and the MAC array; the kernel controller drives offsets and release.

## Interface
- DATA_WIDTH, 8, bits per sample
- DEPTH, 21, samples retained; 2 ≤ DEPTH ≤ 2^ADDR_WIDTH
- PORTS, 3, number of read ports
- ADDR_WIDTH, 6, offset/pointer width
- i_clk  in  1  sole clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_wr_valid  in  1  write sample offered
- o_wr_ready  out  1  buffer can accept; equals !o_full
- i_wr_data  in  DATA_WIDTH  write sample
- i_release  in  1  retire oldest sample this cycle
- i_rd_en  in  1  launch read on all ports
- i_rd_offs  in  ADDR_WIDTH*PORTS  per-port offset from oldest; port p at bits [ADDR_WIDTH*p +: ADDR_WIDTH]
- o_rd_data  out  DATA_WIDTH*PORTS  per-port read data, same packing
- o_rd_valid  out  1  o_rd_data/o_rd_oob valid
- o_rd_oob  out  PORTS  per-port out-of-range flag
- o_fill  out  ADDR_WIDTH+1  samples currently held
- o_full  out  1  o_fill == DEPTH
- o_empty  out  1  o_fill == 0

## Operation
- State: write pointer wp, tail pointer tp, both in 0..DEPTH-1; fill counter.
- Write: fires when i_wr_valid && o_wr_ready. Stores at mem[wp]; wp advances with wrap DEPTH-1 → 0. Non-power-of-two wrap is compare-and-clear, not a bit mask.
- Release: fires when i_release && !o_empty; tp advances with the same wrap. Release when empty is ignored.
- Fill: +1 on write only, -1 on release only, unchanged when both fire.
- o_wr_ready: depends only on registered fill. A release in the same cycle does not enable a write while full.
- Read address per port: (tp + offs) reduced mod DEPTH by a single conditional subtract. Port is in range iff offs < fill, using pre-update fill and tp.
- Read result: in-range port returns mem[addr]. Out-of-range port returns 0 and sets its o_rd_oob bit.
- Read with concurrent release: uses pre-release tp, so offset 0 still returns the sample being released.
- Memory array is not reset; initialised to 0 at configuration.
- Reset mid-operation: pointers and fill clear immediately. Stale contents are unreachable because every offset is then out of range.

## Timing
- Reset values:
  - o_rd_data = 0, o_rd_valid = 0, o_rd_oob = 0.
  - o_fill = 0, o_full = 0, o_empty = 1, o_wr_ready = 1.
- Read latency 1 cycle: i_rd_en at edge N gives o_rd_valid=1 with data after edge N+1, for one cycle. Data holds until the next read.
- Back-to-back reads every cycle are supported.
- o_fill, o_full, o_empty and o_wr_ready update 1 cycle after the write/release edge.
- A write at edge N is readable by a read launched at edge N+1. Same-edge behaviour depends on Configuration.

## Configuration
- WINDOW_BRAM_BYPASS_EN defined:
  - A read launched in the same cycle as an accepted write, with offs == fill, counts as in range.
  - That port returns i_wr_data (write-first forwarding), o_rd_oob bit = 0.
- Undefined:
  - Such a port is out of range: data 0, o_rd_oob bit = 1.
  - No forwarding mux is built.

## Test plan
- Reset, write 21 samples 1..21:
  - o_full=1, o_wr_ready=0, o_fill=21.
  - 22nd write is not accepted; o_fill stays 21.
- Full buffer, offsets {0,10,20}, i_rd_en:
  - Next cycle o_rd_data = {21,11,1} (port 2 upper), o_rd_valid=1 for one cycle, o_rd_oob=0.
- Release 5 and write 22..26 concurrently:
  - o_fill stays 21.
  - Offset 0 reads 6; offset 20 reads 26, confirming wrap of both pointers.
- Fill=3, offsets {0,3,7}:
  - Port 0 returns the oldest sample; ports 1 and 2 return 0 with o_rd_oob=3'b110.
- Empty buffer, write 0xAB and read offset 0 in the same cycle:
  - With WINDOW_BRAM_BYPASS_EN: data 0xAB, oob 0.
  - Without: data 0, oob 1.
- Assert i_rst mid-stream with fill=12:
  - Outputs go to reset values without a clock edge.
  - A subsequent read at offset 0 flags oob.
